// File: rtl/main_memory_ctrl.sv
// Fixed-latency backing store behind the cache controller: accepts one request in IDLE,
// waits max(WAIT_CYCLES,1) cycles, then commits/reads and pulses MReady. Option: MEM_PROTO_ERR_EN.
module main_memory_ctrl #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MStrobe,
  input  logic              MRW,
  input  logic [ADDR_W-1:0] MAddr,
  input  logic [DATA_W-1:0] MDataIn,
  output logic [DATA_W-1:0] MDataOut,
  output logic              MReady,
`ifdef MEM_PROTO_ERR_EN
  output logic              MErr,
`endif
  output logic              MBusy
);

  localparam int unsigned Depth = 1 << ADDR_W;
  // A zero wait count behaves like one: the counter starts at 0 and WAIT lasts a single cycle.
  localparam logic [7:0] CntInit = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_q [Depth];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    mem_we  = 1'b0;

    case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (MStrobe) begin
          addr_d  = MAddr;
          data_d  = MDataIn;
          rw_d    = MRW;
          cnt_d   = CntInit;
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 8'd0) begin
          // Commit on the edge entering DONE so a following read sees the new data.
          ready_d = 1'b1;
          state_d = StDone;
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem_q[addr_q];
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Array is deliberately not reset; an aborted write never reaches StDone so never commits.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[addr_q] <= data_q;
    end
  end

`ifdef MEM_PROTO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (MStrobe && (state_q != StIdle)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign MErr = err_q;
`endif

  assign MDataOut = dout_q;
  assign MReady   = ready_q;
  assign MBusy    = busy_q;

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Drives three controllers (WAIT_CYCLES 4, 1, 0) with shared stimulus and compares each
// cycle against a request-age reference model.
module tb_main_memory_ctrl;

  logic       clk;
  logic       reset;
  logic       strobe;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] din;

  logic [2:0][7:0] dout;
  logic [2:0]      rdy;
  logic [2:0]      busy;
`ifdef MEM_PROTO_ERR_EN
  logic [2:0]      err;
`endif

  main_memory_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(4)) u_dut_w4 (
    .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr), .MDataIn(din),
    .MDataOut(dout[0]), .MReady(rdy[0]),
`ifdef MEM_PROTO_ERR_EN
    .MErr(err[0]),
`endif
    .MBusy(busy[0])
  );

  main_memory_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr), .MDataIn(din),
    .MDataOut(dout[1]), .MReady(rdy[1]),
`ifdef MEM_PROTO_ERR_EN
    .MErr(err[1]),
`endif
    .MBusy(busy[1])
  );

  main_memory_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr), .MDataIn(din),
    .MDataOut(dout[2]), .MReady(rdy[2]),
`ifdef MEM_PROTO_ERR_EN
    .MErr(err[2]),
`endif
    .MBusy(busy[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: effective wait per DUT and the age of the in-flight request
  // (-1 idle, 0 on the accepting edge, W on the edge that completes it).
  int         wv [3] = '{4, 1, 1};
  int         age [3];
  bit         lrw [3];
  logic [7:0] laddr [3];
  logic [7:0] ldata [3];
  logic [7:0] mem_m [3][256];
  bit         known_m [3][256];
  logic [7:0] dout_m [3];
  bit         dout_known [3];
  bit         err_m [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      age[d]        = -1;
      dout_m[d]     = 8'h00;
      dout_known[d] = 1'b1;
      err_m[d]      = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 3; d++) begin
      if (age[d] < 0) begin
        if (strobe) begin
          age[d]   = 0;
          lrw[d]   = rw;
          laddr[d] = addr;
          ldata[d] = din;
        end
      end else begin
        if (strobe) err_m[d] = 1'b1;
        age[d]++;
        if (age[d] > wv[d]) begin
          age[d] = -1;
        end else if (age[d] == wv[d]) begin
          if (lrw[d]) begin
            mem_m[d][laddr[d]]   = ldata[d];
            known_m[d][laddr[d]] = 1'b1;
          end else begin
            dout_m[d]     = mem_m[d][laddr[d]];
            dout_known[d] = known_m[d][laddr[d]];
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("busy[%0d]", d), 32'(busy[d]), 32'(age[d] >= 0));
      check($sformatf("ready[%0d]", d), 32'(rdy[d]), 32'(age[d] == wv[d]));
      if (dout_known[d]) check($sformatf("dout[%0d]", d), 32'(dout[d]), 32'(dout_m[d]));
`ifdef MEM_PROTO_ERR_EN
      check($sformatf("err[%0d]", d), 32'(err[d]), 32'(err_m[d]));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic issue(input bit w, input logic [7:0] a, input logic [7:0] dat);
    strobe = 1'b1;
    rw     = w;
    addr   = a;
    din    = dat;
    step();
    strobe = 1'b0;
    rw     = 1'($urandom);
    addr   = 8'($urandom);
    din    = 8'($urandom);
    repeat (6) step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic mid_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset  = 1'b0;
    strobe = 1'b0;
    rw     = 1'b0;
    addr   = 8'h00;
    din    = 8'h00;
    model_reset();
    repeat (2) step();
    check("rst_dout", 32'(dout[0]), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();

    issue(1'b0, 8'h10, 8'h00);
    issue(1'b1, 8'h00, 8'h33);
    issue(1'b1, 8'h3C, 8'h5A);
    issue(1'b0, 8'h3C, 8'h00);
    check("readback_5a", 32'(dout[0]), 32'h5A);

    // Strobe held through busy cycles, address switched after acceptance.
    strobe = 1'b1;
    rw     = 1'b0;
    addr   = 8'h3C;
    step();
    addr = 8'h00;
    repeat (11) step();
    strobe = 1'b0;
    repeat (6) step();
    check("held_strobe_dout", 32'(dout[0]), 32'h33);

    // Write aborted by reset after two edges; the slow instance must not commit it.
    strobe = 1'b1;
    rw     = 1'b1;
    addr   = 8'h3C;
    din    = 8'hFF;
    step();
    strobe = 1'b0;
    step();
    mid_reset();
    step();
    issue(1'b0, 8'h3C, 8'h00);
    check("abort_w4", 32'(dout[0]), 32'h5A);
    check("abort_w1", 32'(dout[1]), 32'hFF);

    // Minimum latency path.
    issue(1'b1, 8'h01, 8'hA5);
    issue(1'b0, 8'h01, 8'h00);
    check("minlat_w1", 32'(dout[1]), 32'hA5);
    check("minlat_w0", 32'(dout[2]), 32'hA5);

    for (int i = 0; i < 600; i++) begin
      strobe = ($urandom_range(0, 2) == 0);
      rw     = 1'($urandom);
      addr   = 8'($urandom_range(0, 7));
      din    = 8'($urandom);
      step();
      if ($urandom_range(0, 149) == 0) mid_reset();
    end
    strobe = 1'b0;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
